etm_mul_arbiter: RTL and testbench



---
 rtl/etm_mul_arbiter.sv | 134 +++++++++++++
 tb/tb_etm_mul_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etm_mul_arbiter.sv
// Round-robin arbiter sharing one ETM 16x16 multiplier between N_REQ requesters,
// with a single registered result stage. Optional counters under `ETM_STATS_EN`.
module etm_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_approx
`ifdef ETM_STATS_EN
  ,
  output logic [15:0]           stat_total,
  output logic [15:0]           stat_approx
`endif
);

  // Handshake: a transfer happens on a rising edge when valid and ready are both high.

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            valid_q;
  logic [ID_W-1:0] id_q;
  logic [31:0]     result_q, result_d;
  logic            approx_q, approx_d;

  logic            found;
  logic [ID_W-1:0] cand;
  logic            can_accept;
  logic            accept;
  logic [15:0]     op_a, op_b;

  // Candidate search starts at ptr_q and wraps; only the rotated offset is computed in int.
  always_comb begin
    int idx;
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    for (int j = 0; j < N_REQ; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        cand  = ID_W'(idx);
      end
    end
  end

  assign can_accept = !valid_q || rsp_ready;
  assign accept     = can_accept && found;
  assign ptr_d      = (cand == ID_W'(N_REQ-1)) ? '0 : cand + 1'b1;

  always_comb begin
    req_ready = '0;
    op_a      = '0;
    op_b      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand == ID_W'(i)) begin
        req_ready[i] = accept;
        op_a         = req_a[16*i +: 16];
        op_b         = req_b[16*i +: 16];
      end
    end
  end

  // ETM: exact low-byte product when both high bytes are zero, otherwise the high
  // product with a saturated-ones low half reaching 8 bits above the top set bit.
  always_comb begin
    logic [7:0]  or_lo;
    logic [15:0] u;
    logic [15:0] prod_lo, prod_hi;
    or_lo   = op_a[7:0] | op_b[7:0];
    prod_lo = {8'd0, op_a[7:0]} * {8'd0, op_b[7:0]};
    prod_hi = {8'd0, op_a[15:8]} * {8'd0, op_b[15:8]};
    u       = '0;
    for (int k = 0; k < 8; k++) begin
      if (or_lo[k]) u = 16'hFFFF >> (7 - k);
    end
    if (op_a[15:8] == 8'd0 && op_b[15:8] == 8'd0) begin
      result_d = {16'd0, prod_lo};
      approx_d = 1'b0;
    end else begin
      result_d = {prod_hi, u};
      approx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      result_q <= '0;
      approx_q <= 1'b0;
    end else if (accept) begin
      ptr_q    <= ptr_d;
      valid_q  <= 1'b1;
      id_q     <= cand;
      result_q <= result_d;
      approx_q <= approx_d;
    end else if (rsp_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign rsp_valid  = valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_approx = approx_q;

`ifdef ETM_STATS_EN
  logic [15:0] stat_total_q, stat_approx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total_q  <= '0;
      stat_approx_q <= '0;
    end else if (accept) begin
      if (stat_total_q != 16'hFFFF) stat_total_q <= stat_total_q + 16'd1;
      if (approx_d && stat_approx_q != 16'hFFFF) stat_approx_q <= stat_approx_q + 16'd1;
    end
  end

  assign stat_total  = stat_total_q;
  assign stat_approx = stat_approx_q;
`endif

endmodule

// File: tb/tb_etm_mul_arbiter.sv
// Self-checking bench for etm_mul_arbiter: directed ETM/arbitration scenarios plus
// randomized traffic against a behavioural model and an expected-result queue.
module tb_etm_mul_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_approx;
`ifdef ETM_STATS_EN
  logic [15:0]     stat_total, stat_approx;
`endif

  etm_mul_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_approx(rsp_approx)
`ifdef ETM_STATS_EN
    , .stat_total(stat_total), .stat_approx(stat_approx)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state and scoreboard
  int  m_ptr = 0;
  bit  m_full = 0;
  logic [IW+32:0] exp_q[$];

  function automatic logic [32:0] etm_ref(input int unsigned a, input int unsigned b);
    int unsigned o, k;
    longint unsigned u;
    if (a < 256 && b < 256) return {1'b0, 32'(a * b)};
    o = (a | b) & 32'd255;
    u = 0;
    if (o != 0) begin
      k = $clog2(o + 1) - 1;
      u = (64'd1 << (k + 9)) - 1;
    end
    return {1'b1, 16'((a >> 8) * (b >> 8)), 16'(u)};
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_full = 0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one cycle: inputs already driven at negedge; check, predict, advance to next negedge
  task automatic tick(output int grant);
    logic [N-1:0]   exp_rdy;
    logic [IW+32:0] got, exp;
    logic [32:0]    r;
    grant   = -1;
    exp_rdy = '0;
    if (!m_full || rsp_ready) begin
      for (int j = 0; j < N; j++) begin
        int idx;
        idx = (m_ptr + j) % N;
        if (grant < 0 && req_valid[idx]) grant = idx;
      end
    end
    if (grant >= 0) exp_rdy[grant] = 1'b1;
    #1;
    vectors++;
    if (req_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL req_ready: got %b expected %b", req_ready, exp_rdy);
    end
    vectors++;
    if (rsp_valid !== m_full) begin
      miscompares++;
      $display("FAIL rsp_valid: got %b expected %b", rsp_valid, m_full);
    end
    if (m_full && rsp_ready) begin
      got = {rsp_id, rsp_approx, rsp_result};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL drain: unexpected result %h", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL drain: got id/approx/result %h expected %h", got, exp);
        end
      end
    end
    if (grant >= 0) begin
      r = etm_ref(32'(req_a[16*grant +: 16]), 32'(req_b[16*grant +: 16]));
      exp_q.push_back({IW'(grant), r});
      m_ptr  = (grant + 1) % N;
      m_full = 1;
    end else if (rsp_ready) begin
      m_full = 0;
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic send_one(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_res, input logic exp_apx);
    int g;
    req_valid           = '0;
    req_valid[id]       = 1'b1;
    req_a[16*id +: 16]  = a;
    req_b[16*id +: 16]  = b;
    rsp_ready           = 1'b1;
    tick(g);
    req_valid = '0;
    vectors++;
    if (rsp_result !== exp_res || rsp_approx !== exp_apx || rsp_id !== IW'(id)) begin
      miscompares++;
      $display("FAIL etm a=%h b=%h: got %h/%b/%0d expected %h/%b/%0d",
               a, b, rsp_result, rsp_approx, rsp_id, exp_res, exp_apx, id);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_approx !== 1'b0 ||
        rsp_id !== '0 || req_ready !== '0) begin
      miscompares++;
      $display("FAIL reset: got valid=%b result=%h approx=%b id=%0d ready=%b expected all 0",
               rsp_valid, rsp_result, rsp_approx, rsp_id, req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_exact();
    int g;
    send_one(0, 16'h0012, 16'h0034, 32'h000003A8, 1'b0);
    tick(g);
  endtask

  task automatic test_approx();
    int g;
    send_one(2, 16'h0210, 16'h0301, 32'h00061FFF, 1'b1);
    send_one(2, 16'hFF80, 16'h0100, 32'h00FFFFFF, 1'b1);
    send_one(2, 16'h0100, 16'h0100, 32'h00010000, 1'b1);
    send_one(1, 16'h0101, 16'h0000, 32'h000001FF, 1'b1);
    tick(g);
  endtask

  task automatic test_round_robin();
    int g;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = 16'($urandom);
      req_b[16*i +: 16] = 16'($urandom);
    end
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      tick(g);
      vectors++;
      if (g != exp_order[n] || req_valid[exp_order[n]] !== 1'b1) begin
        miscompares++;
        $display("FAIL rr grant %0d: model %0d expected %0d", n, g, exp_order[n]);
      end
      vectors++;
      if (rsp_id !== IW'(exp_order[n])) begin
        miscompares++;
        $display("FAIL rr rsp_id %0d: got %0d expected %0d", n, rsp_id, exp_order[n]);
      end
    end
    req_valid = '0;
    tick(g);
  endtask

  task automatic test_backpressure();
    int g;
    logic [IW+33:0] held;
    req_valid = '1;
    rsp_ready = 1'b1;
    tick(g);
    held      = {rsp_valid, rsp_id, rsp_approx, rsp_result};
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      req_a[16*((g+1)%N) +: 16] = req_a[16*((g+1)%N) +: 16];
      tick(g);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_approx, rsp_result} !== held) begin
        miscompares++;
        $display("FAIL stall %0d: got %h expected %h", n,
                 {rsp_valid, rsp_id, rsp_approx, rsp_result}, held);
      end
    end
    rsp_ready = 1'b1;
    tick(g);
    req_valid = '0;
    tick(g);
    tick(g);
  endtask

  task automatic test_reset_mid();
    int g;
    req_valid = '1;
    rsp_ready = 1'b1;
    apply_reset();
    req_valid = '1;
    tick(g);
    rsp_ready = 1'b0;
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async reset: rsp_valid got %b expected 0", rsp_valid);
    end
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    tick(g);
    vectors++;
    if (rsp_id !== 2'd0 || g != 0) begin
      miscompares++;
      $display("FAIL post-reset grant: got %0d expected 0", rsp_id);
    end
    req_valid = '0;
    tick(g);
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          if ($urandom_range(0, 2) == 0) begin
            req_a[16*i +: 16] = 16'($urandom_range(0, 255));
            req_b[16*i +: 16] = 16'($urandom_range(0, 255));
          end else begin
            req_a[16*i +: 16] = 16'($urandom);
            req_b[16*i +: 16] = 16'($urandom);
          end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick(g);
    tick(g);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL random drain: %0d results never returned", exp_q.size());
    end
  endtask

`ifdef ETM_STATS_EN
  task automatic test_stats();
    int g;
    apply_reset();
    send_one(0, 16'h0003, 16'h0005, 32'h0000000F, 1'b0);
    send_one(1, 16'h0100, 16'h0100, 32'h00010000, 1'b1);
    send_one(2, 16'h0010, 16'h0010, 32'h00000100, 1'b0);
    send_one(3, 16'h0210, 16'h0301, 32'h00061FFF, 1'b1);
    send_one(0, 16'h00FF, 16'h00FF, 32'h0000FE01, 1'b0);
    vectors++;
    if (stat_total !== 16'd5 || stat_approx !== 16'd2) begin
      miscompares++;
      $display("FAIL stats: got %0d/%0d expected 5/2", stat_total, stat_approx);
    end
    force dut.stat_total_q = 16'hFFFF;
    #1;
    release dut.stat_total_q;
    send_one(1, 16'h0001, 16'h0001, 32'h00000001, 1'b0);
    vectors++;
    if (stat_total !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL stats saturate: got %h expected FFFF", stat_total);
    end
    tick(g);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_exact();
    test_approx();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef ETM_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
